ps2_tx: RTL

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/ps2_tx_pkg.sv | 26 ++
 rtl/ps2_filter.sv | 31 +++
 rtl/ps2_tx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ps2_tx_pkg.sv
// Shared PS/2 defines: host-transmit FSM states,
// command bytes and the odd-parity helper.
package ps2_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    DATA,
    PARITY,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  localparam logic [3:0] PARITY_EDGE  = 4'd8;

  function automatic logic odd_parity(
    input logic [7:0] d
  );
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 line conditioner: 2-FF sync then a LEN-sample
// stability filter. Ports: clk, reset_n, raw -> filt.
module ps2_filter #(
  parameter int LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filt
);

  logic [1:0]     sync;
  logic [LEN-1:0] hist;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= 2'b11;
      hist <= '1;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      hist <= (hist << 1) | LEN'(sync[1]);
      if (&hist) begin
        filt <= 1'b1;
      end else if (~|hist) begin
        filt <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte transmitter with ACK check.
// Ports: tx_valid/tx_data/tx_ready, ps2 pins, busy/done/err.
module ps2_tx
  import ps2_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IW-1:0] INH_LAST =
    IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    state;
  logic [7:0]    byte_q;
  logic          par_q;
  logic          nack_q;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          clk_q;
  logic          clk_filt;
  logic          data_filt;
  logic          clk_fall;
  logic          line_idle;

  ps2_filter #(.LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (ps2_clk_in),
    .filt    (clk_filt)
  );

  ps2_filter #(.LEN(FILTER_LEN)) u_data_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (ps2_data_in),
    .filt    (data_filt)
  );

  assign clk_fall  = clk_q & ~clk_filt;
  assign line_idle = clk_filt & data_filt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      byte_q      <= '0;
      par_q       <= 1'b0;
      nack_q      <= 1'b0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      tmo_cnt     <= '0;
      clk_q       <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      tx_ready    <= 1'b0;
    end else begin
      clk_q <= clk_filt;
      done  <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            byte_q     <= tx_data;
            par_q      <= odd_parity(tx_data);
            inh_cnt    <= '0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          if (inh_cnt == INH_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          tmo_cnt <= '0;
          bit_cnt <= '0;
          state   <= DATA;
        end
        default: begin
          // a device edge beats a same-cycle timeout
          if (clk_fall) begin
            tmo_cnt <= '0;
            if (state != WAIT_IDLE) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
            unique case (state)
              DATA: begin
                if (bit_cnt == PARITY_EDGE) begin
                  ps2_data_oe <= ~par_q;
                  state       <= PARITY;
                end else begin
                  ps2_data_oe <= ~byte_q[bit_cnt[2:0]];
                end
              end
              PARITY: begin
                ps2_data_oe <= 1'b0;
                state       <= ACK;
              end
              ACK: begin
                nack_q <= data_filt;
                state  <= WAIT_IDLE;
              end
              default: ;
            endcase
          end else if (state == WAIT_IDLE && line_idle) begin
            done  <= 1'b1;
            err   <= nack_q;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b1;
            err         <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
